pdm_modulator: RTL and testbench

Transmit-side counterpart of the PDM microphone front end and FIR decimator chain. It accepts signed 16-bit PCM samples through a valid/ready handshake and re-modulates them into a 1-bit pulse-density stream with a first-order delta-sigma modulator. It generates its own PDM bit clock and feeds speaker/line-out PDM pins. It also closes the loop in simulation, where its output is fed back through the decimator chain.

---
 rtl/pdm_modulator_if.sv | 9 +
 rtl/pdm_modulator.sv | 163 ++++++++++++++++
 tb/tb_pdm_modulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pdm_modulator_if.sv
// PCM sample handshake into the PDM modulator: a signed sample qualified by valid, with ready returned.
interface pdm_modulator_if;
  logic signed [15:0] audio_in;
  logic               audio_sample_valid;
  logic               ready_for_input;

  modport master (output audio_in, output audio_sample_valid, input ready_for_input);
  modport slave  (input audio_in, input audio_sample_valid, output ready_for_input);
endinterface

// File: rtl/pdm_modulator.sv
// First-order delta-sigma PCM->PDM modulator with its own bit clock and a one-entry sample buffer.
// Optional PDM_MOD_LINEAR_INTERP_EN: linear interpolation prev->cur across each sample period.
module pdm_modulator #(
  parameter int PDM_COUNT_PERIOD = 32,
  parameter int OSR_LOG2         = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  pdm_modulator_if.slave   aud,
  output logic             pdm_clk_out,
  output logic             pdm_out,
  output logic             pdm_step_out,
  output logic             underflow_out
);

  localparam int CW = $clog2(PDM_COUNT_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(PDM_COUNT_PERIOD / 2);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic [15:0]          buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [15:0]          cur_q, cur_d;
  logic [OSR_LOG2-1:0]  k_q, k_d;
  logic [15:0]          acc_q, acc_d;
  logic                 pdm_q, pdm_d;
  logic                 step_q;
  logic                 unf_q, unf_d;

  logic                 step, boundary, accept, load, drain, roll;
  logic [15:0]          v, u;
  logic [16:0]          sum;

`ifdef PDM_MOD_LINEAR_INTERP_EN
  logic [15:0]                 prev_q, prev_d;
  logic signed [16:0]          diff;
  logic signed [17+OSR_LOG2:0] prod;
`endif

  assign cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign step      = (cnt_d == CNT_HALF);
  assign pdm_clk_d = (cnt_d < CNT_HALF);
  assign boundary  = (k_q == {OSR_LOG2{1'b1}});
  assign accept    = aud.audio_sample_valid & ~buf_full_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && step && buf_full_q) state_d = RUN;
  end

  always_comb begin
    load  = 1'b0;
    drain = 1'b0;
    roll  = 1'b0;
    unf_d = 1'b0;
    v     = '0;
    case (state_q)
      IDLE: begin
        load  = step & buf_full_q;
        drain = load;
      end
      RUN: begin
`ifdef PDM_MOD_LINEAR_INTERP_EN
        v = prev_q + prod[OSR_LOG2 +: 16];
`else
        v = cur_q;
`endif
        roll  = step & boundary;
        drain = roll & buf_full_q;
        unf_d = roll & ~buf_full_q;
      end
      default: ;
    endcase
  end

`ifdef PDM_MOD_LINEAR_INTERP_EN
  // floor((cur-prev)*k / OSR) via the upper product bits; the result always fits 16 bits
  assign diff = $signed({cur_q[15], cur_q}) - $signed({prev_q[15], prev_q});
  assign prod = $signed({{(OSR_LOG2+1){diff[16]}}, diff}) * $signed({18'b0, k_q});
`endif

  // Offset binary: v + 32768 is just the sign bit flipped
  assign u   = {~v[15], v[14:0]};
  assign sum = {1'b0, acc_q} + {1'b0, u};

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    k_d        = k_q;
    acc_d      = acc_q;
    pdm_d      = pdm_q;
    if (accept) begin
      buf_d      = aud.audio_in;
      buf_full_d = 1'b1;
    end
    if (drain) begin
      buf_full_d = 1'b0;
      cur_d      = buf_q;
    end
    if (load)                        k_d = '0;
    else if (state_q == RUN && step) k_d = k_q + 1'b1;
    if (step) begin
      acc_d = sum[15:0];
      pdm_d = sum[16];
    end
  end

`ifdef PDM_MOD_LINEAR_INTERP_EN
  always_comb begin
    prev_d = prev_q;
    if (load)      prev_d = buf_q;
    else if (roll) prev_d = cur_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) prev_q <= '0;
    else        prev_q <= prev_d;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      pdm_clk_q  <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      pdm_q      <= 1'b0;
      step_q     <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      pdm_q      <= pdm_d;
      step_q     <= step;
      unf_q      <= unf_d;
    end
  end

  assign aud.ready_for_input = ~buf_full_q;
  assign pdm_clk_out         = pdm_clk_q;
  assign pdm_out             = pdm_q;
  assign pdm_step_out        = step_q;
  assign underflow_out       = unf_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator (default zero-order-hold build): bit clock, densities, handshake, underflow, reset.
module tb_pdm_modulator;
  localparam int PERIOD = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic pdm_clk_out, pdm_out, pdm_step_out, underflow_out;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk_in = ~clk_in;

  pdm_modulator_if aud_if ();

  pdm_modulator #(.PDM_COUNT_PERIOD(PERIOD), .OSR_LOG2(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .aud           (aud_if.slave),
    .pdm_clk_out   (pdm_clk_out),
    .pdm_out       (pdm_out),
    .pdm_step_out  (pdm_step_out),
    .underflow_out (underflow_out)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_pdm_clk"}, int'(pdm_clk_out), 0);
    check_val({tag, "_pdm_out"}, int'(pdm_out), 0);
    check_val({tag, "_step"}, int'(pdm_step_out), 0);
    check_val({tag, "_unf"}, int'(underflow_out), 0);
    check_val({tag, "_rdy"}, int'(aud_if.ready_for_input), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    aud_if.audio_sample_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Waits for the next PDM step; reports cycles waited and cycles since the last bit-clock rise
  task automatic step_wait(output int gap, output int since_rise, output int bit_o);
    int   c = 0;
    int   rise = -1000;
    logic prev_clk = pdm_clk_out;
    do begin
      @(posedge clk_in);
      #1;
      c++;
      if (pdm_clk_out && !prev_clk) rise = c;
      prev_clk = pdm_clk_out;
    end while (!pdm_step_out && c < 200);
    gap        = c;
    since_rise = c - rise;
    bit_o      = int'(pdm_out);
  endtask

  // Runs n PDM steps, optionally holding valid high with val; tallies ones, underflows and accepts
  task automatic run_steps(input string tag, input int n, input bit feed, input logic [15:0] val,
                           output int ones, output int unf, output int accepts);
    int steps = 0;
    int cyc   = 0;
    ones = 0; unf = 0; accepts = 0;
    while (steps < n && cyc < n * PERIOD + 64) begin
      @(negedge clk_in);
      aud_if.audio_in           = val;
      aud_if.audio_sample_valid = feed;
      if (feed && aud_if.ready_for_input) accepts++;
      @(posedge clk_in);
      #1;
      cyc++;
      if (underflow_out) unf++;
      if (pdm_step_out) begin
        steps++;
        if (pdm_out) ones++;
      end
    end
    aud_if.audio_sample_valid = 1'b0;
    check_val({tag, "_steps"}, steps, n);
  endtask

  task automatic send_sample(input logic [15:0] val);
    int c = 0;
    @(negedge clk_in);
    while (!aud_if.ready_for_input && c < 20000) begin
      @(negedge clk_in);
      c++;
    end
    check_val("send_rdy", int'(aud_if.ready_for_input), 1);
    aud_if.audio_in           = val;
    aud_if.audio_sample_valid = 1'b1;
    @(negedge clk_in);
    aud_if.audio_sample_valid = 1'b0;
  endtask

  initial begin
    int gap, since, b, ones, unf, acc;
    aud_if.audio_in           = '0;
    aud_if.audio_sample_valid = 1'b0;

    // Reset values while reset is held for two cycles
    @(posedge clk_in); #1;
    check_reset_outs("rst1");
    @(posedge clk_in); #1;
    check_reset_outs("rst2");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Silence after reset: alternating bits, steps 16 then every 32 clocks, 16 after each bit-clock rise
    for (int i = 0; i < 8; i++) begin
      step_wait(gap, since, b);
      check_val($sformatf("sil_gap%0d", i), gap, (i == 0) ? 16 : 32);
      check_val($sformatf("sil_bit%0d", i), b, i % 2);
      check_val($sformatf("sil_clk%0d", i), int'(pdm_clk_out), 0);
      if (i > 0) check_val($sformatf("sil_rise%0d", i), since, 16);
    end
    check_val("sil_rdy", int'(aud_if.ready_for_input), 1);

    // Negative full scale: all zeros
    do_reset();
    run_steps("neg", 260, 1'b1, 16'h8000, ones, unf, acc);
    check_val("neg_ones", ones, 0);
    check_val("neg_unf", unf, 0);

    // Positive full scale: IDLE step gives 0, then 300 ones
    do_reset();
    run_steps("pos", 301, 1'b1, 16'h7FFF, ones, unf, acc);
    check_val("pos_ones", ones, 300);
    check_val("pos_unf", unf, 0);

    // Back-to-back offers of 0x4000: one accept per sample period, 3/4 density
    do_reset();
    run_steps("hs", 513, 1'b1, 16'h4000, ones, unf, acc);
    check_val("hs_accepts", acc, 3);
    check_val("hs_ones", ones, 384);
    check_val("hs_unf", unf, 0);

    // Underflow: single sample, then a late sample picked up at the following boundary
    do_reset();
    send_sample(16'h4000);
    run_steps("uf1", 257, 1'b0, 16'h0000, ones, unf, acc);
    check_val("uf1_ones", ones, 192);
    check_val("uf1_unf", unf, 1);
    send_sample(16'h8000);
    run_steps("uf2", 256, 1'b0, 16'h0000, ones, unf, acc);
    check_val("uf2_ones", ones, 192);
    check_val("uf2_unf", unf, 0);
    check_val("uf2_rdy", int'(aud_if.ready_for_input), 1);
    run_steps("uf3", 16, 1'b0, 16'h0000, ones, unf, acc);
    check_val("uf3_ones", ones, 0);

    // Reset mid-stream with buffer full at k=100
    do_reset();
    run_steps("mid", 101, 1'b1, 16'h4000, ones, unf, acc);
    check_val("mid_full", int'(aud_if.ready_for_input), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_reset_outs("mid_rst");
    @(negedge clk_in);
    rst_in = 1'b0;
    run_steps("post", 64, 1'b0, 16'h0000, ones, unf, acc);
    check_val("post_ones", ones, 32);
    check_val("post_unf", unf, 0);
    check_val("post_rdy", int'(aud_if.ready_for_input), 1);

    // Zero-order hold of 0x1000: 144 ones per 256 steps
    do_reset();
    run_steps("zoh0", 1, 1'b1, 16'h1000, ones, unf, acc);
    run_steps("zoh", 256, 1'b1, 16'h1000, ones, unf, acc);
    check_val("zoh_ones", ones, 144);
    check_val("zoh_unf", unf, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
